// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared address map, CON bit layout and FSM encodings for the UART TX block
//
// Purpose: constants shared by mmio_uart_tx and its FIFO, and by the data-memory
//          address decode that sits beside this peripheral.
// Ports:   none (package).

package mmio_uart_tx_pkg;

  // Byte offsets from BASE_ADDR
  localparam logic [31:0] TXD_OFF = 32'h0000_0000;
  localparam logic [31:0] CON_OFF = 32'h0000_0004;

  // CON register bit positions
  localparam int CON_FULL  = 0;
  localparam int CON_EMPTY = 1;
  localparam int CON_BUSY  = 2;
  localparam int CON_DONE  = 3;
  localparam int CON_OVF   = 4;
  localparam int CON_PAR   = 5;

  // Serializer FSM encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Width of one UART character
  localparam int UART_DATA_W = 8;

  // Even parity of a character: XOR of all data bits
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// rtl/mmio_uart_tx_fifo.sv - synchronous TX FIFO with wrap-bit pointers
//
// Purpose: holds bytes written to TXD until the serializer takes them.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high; empties the FIFO
//   push   in   write din (ignored while full)
//   pop    in   advance the head (ignored while empty)
//   din    in   byte to enqueue
//   dout   out  current head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held

module uart_tx_fifo
  import mmio_uart_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Extra MSB distinguishes full from empty when the index bits match
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign dout = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_ONE;
      if (pop_ok)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter (TXD/CON registers, FIFO, serializer)
//
// Purpose: CPU data-bus responder. Stores to TXD queue bytes, a serializer drains
//          them as 8N1 frames (8E1 when UART_PARITY_EN is defined), loads of CON
//          return {ovf, done, busy, empty, full} plus the parity-present flag.
// Build option: UART_PARITY_EN inserts an even-parity bit between DATA and STOP.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   Address     in   CPU data address
//   Write_data  in   CPU store data
//   MemRead     in   load strobe
//   MemWrite    in   store strobe
//   Read_data   out  CON contents on a CON load, otherwise 0 (ORed at the top level)
//   uart_tx     out  registered serial line, idles high
//   irq         out  irq_en & done

module mmio_uart_tx #(
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        uart_tx,
  output logic        irq
);

  import mmio_uart_tx_pkg::*;

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bus decode
  logic sel_txd, sel_con, push, con_wr;
  logic unused_wdata;

  assign sel_txd = (Address == (BASE_ADDR + TXD_OFF));
  assign sel_con = (Address == (BASE_ADDR + CON_OFF));
  assign push    = MemWrite & sel_txd;
  assign con_wr  = MemWrite & sel_con;
  assign unused_wdata = ^Write_data[31:8];

  // FIFO
  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_dout;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (Write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serializer state
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             line_d, uart_tx_q;
  logic             cnt_last, done_set;
  logic             par_bit;

  // Status
  logic done_q, ovf_q, irq_en_q;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    done_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_last) begin
          cnt_d    = '0;
          done_set = 1'b1;
          // Back-to-back: next start bit follows the stop bit with no idle time
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef UART_PARITY_EN
  // Parity is captured with the byte since the shift register is consumed by DATA
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (pop) begin
      par_q <= even_parity(fifo_dout);
    end
  end

  assign par_bit = par_q;
`else
  assign par_bit = 1'b1;
`endif

  // Line level follows the next state so uart_tx changes on the same edge as the FSM
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
      ST_PARITY: line_d = par_bit;
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      uart_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      uart_tx_q <= line_d;
    end
  end

  // Sticky flags: a set in the same cycle as a write-one-to-clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      done_q <= done_set | (done_q & ~(con_wr & Write_data[CON_DONE]));
      ovf_q  <= (push & fifo_full) | (ovf_q & ~(con_wr & Write_data[CON_OVF]));
      if (con_wr) irq_en_q <= Write_data[0];
    end
  end

  // CON readback
  logic [31:0] con_word;

  always_comb begin
    con_word            = 32'h0;
    con_word[CON_FULL]  = fifo_full;
    con_word[CON_EMPTY] = fifo_empty;
    con_word[CON_BUSY]  = (state_q != ST_IDLE);
    con_word[CON_DONE]  = done_q;
    con_word[CON_OVF]   = ovf_q;
`ifdef UART_PARITY_EN
    con_word[CON_PAR]   = 1'b1;
`else
    con_word[CON_PAR]   = 1'b0;
`endif
  end

  assign Read_data = (MemRead & sel_con) ? con_word : 32'h0;
  assign uart_tx   = uart_tx_q;
  assign irq       = irq_en_q & done_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx

module tb_mmio_uart_tx;

  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [31:0] PARB  = 32'h20;
`else
  localparam int          NBITS = 10;
  localparam logic [31:0] PARB  = 32'h00;
`endif
  localparam int          FRAME = NBITS * DIV;
  localparam logic [31:0] TXD   = 32'h4000_0018;
  localparam logic [31:0] CON   = 32'h4000_001C;

  logic        clk, reset;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite, uart_tx, irq;

  mmio_uart_tx #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (8),
    .BASE_ADDR  (TXD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .uart_tx    (uart_tx),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    Address    = 32'h0;
    Write_data = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d       = Read_data;
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  // Expected line level i cycles into a frame carrying byte b
  function automatic logic exp_level(input logic [7:0] b, input int i);
    int idx;
    idx = i / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Serial receiver: samples mid-bit, records byte and start cycle
  logic       mon_en;
  logic [7:0] rx_data[$];
  int         rx_start[$];
  logic [7:0] mb;
  int         mt0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_tx === 1'b0) begin
        mt0 = cyc;
        repeat (DIV/2) @(negedge clk);
        check("mon_start_mid", {31'b0, uart_tx}, 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          mb[k] = uart_tx;
        end
`ifdef UART_PARITY_EN
        repeat (DIV) @(negedge clk);
        check("mon_parity", {31'b0, uart_tx}, {31'b0, ^mb});
`endif
        repeat (DIV) @(negedge clk);
        check("mon_stop", {31'b0, uart_tx}, 32'd1);
        rx_data.push_back(mb);
        rx_start.push_back(mt0);
      end
    end
  end

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_data.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("rx_count", rx_data.size(), n);
  endtask

  task automatic send_and_track(input string tag, input logic [7:0] b);
    logic [31:0] rd;
    bus_write(TXD, {24'h0, b});
    @(negedge clk);
    check({tag, "_n1_idle"}, {31'b0, uart_tx}, 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      check({tag, "_line"}, {31'b0, uart_tx}, {31'b0, exp_level(b, i)});
      if (i == FRAME/2) begin
        bus_read(CON, rd);
        check({tag, "_con_busy"}, rd, 32'h6 | PARB);
      end
    end
    @(negedge clk);
    check({tag, "_after_line"}, {31'b0, uart_tx}, 32'd1);
    bus_read(CON, rd);
    check({tag, "_con_done"}, rd, 32'hA | PARB);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        prev_irq, seen;
  int          lows;

  initial begin
    reset = 1'b1; Address = 32'h0; Write_data = 32'h0;
    MemRead = 1'b0; MemWrite = 1'b0; mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    bus_read(CON, rd);
    check("rst_con", rd, 32'h2 | PARB);
    bus_read(TXD, rd);
    check("txd_read_zero", rd, 32'h0);
    Address = CON; #1;
    check("no_read_strobe", Read_data, 32'h0);
    Address = 32'h0;

    // Single byte, every cycle of the frame
    send_and_track("sb55", 8'h55);
    wait_rx(1, 2*FRAME);
    check("sb55_rx", {24'h0, rx_data[0]}, 32'h55);

    // Parity-heavy byte (odd number of ones)
    rx_data.delete(); rx_start.delete();
    bus_write(CON, 32'h18);
    send_and_track("b07", 8'h07);
    wait_rx(1, 2*FRAME);
    check("b07_rx", {24'h0, rx_data[0]}, 32'h07);

    // Back-to-back; upper store bits ignored
    rx_data.delete(); rx_start.delete();
    bus_write(TXD, 32'hFFFF_FFA5);
    bus_write(TXD, 32'h0000_003C);
    wait_rx(2, 3*FRAME);
    check("b2b_rx0", {24'h0, rx_data[0]}, 32'hA5);
    check("b2b_rx1", {24'h0, rx_data[1]}, 32'h3C);
    check("b2b_gap", rx_start[1] - rx_start[0], FRAME);
    repeat (FRAME) @(negedge clk);

    // Overflow
    rx_data.delete(); rx_start.delete();
    bus_write(CON, 32'h18);
    bus_write(TXD, 32'h11);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 9; k++) bus_write(TXD, 32'h20 + k);
    @(negedge clk);
    bus_read(CON, rd);
    check("ovf_con_full", rd, 32'h15 | PARB);
    bus_write(CON, 32'h10);
    @(negedge clk);
    bus_read(CON, rd);
    check("ovf_con_clr", rd, 32'h05 | PARB);
    wait_rx(9, 11*FRAME);
    check("ovf_rx_first", {24'h0, rx_data[0]}, 32'h11);
    for (int k = 1; k < 9; k++) check("ovf_rx_q", {24'h0, rx_data[k]}, 32'h20 + k - 1);
    repeat (2*FRAME) @(negedge clk);
    check("ovf_no_extra", rx_data.size(), 9);

    // IRQ rises with done, clears with done
    bus_write(CON, 32'h18);
    bus_write(CON, 32'h1);
    @(negedge clk);
    check("irq_idle", {31'b0, irq}, 32'd0);
    bus_write(TXD, 32'h0);
    seen = 1'b0; prev_irq = 1'b0;
    for (int t = 0; t < 2*FRAME && !seen; t++) begin
      @(negedge clk);
      bus_read(CON, rd);
      if (rd[3]) begin
        seen = 1'b1;
        check("irq_with_done", {31'b0, irq}, 32'd1);
        check("irq_before_done", {31'b0, prev_irq}, 32'd0);
      end
      prev_irq = irq;
    end
    check("irq_done_seen", {31'b0, seen}, 32'd1);
    bus_write(CON, 32'h8);
    @(negedge clk);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    bus_read(CON, rd);
    check("irq_con_after", rd, 32'h2 | PARB);

    // done set and cleared on the same edge: set wins
    bus_write(CON, 32'h1);
    bus_write(TXD, 32'h3C);
    repeat (FRAME) @(posedge clk);
    #1;
    bus_read(CON, rd);
    check("same_pre_done", {31'b0, rd[3]}, 32'd0);
    bus_write(CON, 32'h9);
    @(negedge clk);
    bus_read(CON, rd);
    check("same_done_kept", rd, 32'hA | PARB);
    check("same_irq", {31'b0, irq}, 32'd1);
    repeat (DIV) @(negedge clk);

    // Reset during DATA bit 3; queued bytes are discarded
    mon_en = 1'b0;
    bus_write(TXD, 32'h55);
    repeat (45) @(negedge clk);
    bus_write(TXD, 32'h66);
    bus_write(TXD, 32'h77);
    check("mf_pre_line", {31'b0, uart_tx}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mf_line", {31'b0, uart_tx}, 32'd1);
    check("mf_irq", {31'b0, irq}, 32'd0);
    bus_read(CON, rd);
    check("mf_con", rd, 32'h2 | PARB);
    lows = 0;
    for (int t = 0; t < 3*FRAME; t++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("mf_no_send", lows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
